// File: rtl/cmd_word_parser.sv
// cmd_word_parser: pulls header + payload words from a show-ahead FIFO and
// presents each complete command downstream as one parallel packet.
module cmd_word_parser #(
  parameter int DW   = 32,
  parameter int MAXW = 4
) (
  input  logic                 i_clk,
  input  logic                 i_resetn,
  input  logic                 i_fifo_empty,
  input  logic [DW-1:0]        i_fifo_data,
  output logic                 o_fifo_rd,
  output logic                 o_cmd_valid,
  input  logic                 i_cmd_ready,
  output logic [7:0]           o_cmd_op,
  output logic [3:0]           o_cmd_len,
  output logic [MAXW*DW-1:0]   o_cmd_payload,
  output logic                 o_err,
  output logic                 o_busy
);

  typedef enum logic [1:0] {HDR, PAY, DRAIN, OUT} state_t;

  localparam logic [3:0] MAXW_L = 4'(MAXW);

  state_t     state_q;
  state_t     state_d;
  logic       pop;
  logic [3:0] hdr_len;
  logic [3:0] cnt_q;

  assign hdr_len = i_fifo_data[3:0];

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state_q <= HDR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; word-consuming states only move on a pop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HDR: begin
        if (pop) begin
          if (hdr_len == 4'd0) begin
            state_d = OUT;
          end else if (hdr_len > MAXW_L) begin
            state_d = DRAIN;
          end else begin
            state_d = PAY;
          end
        end
      end
      PAY: begin
        if (pop && (cnt_q == o_cmd_len - 4'd1)) begin
          state_d = OUT;
        end
      end
      DRAIN: begin
        if (pop && (cnt_q == 4'd1)) begin
          state_d = HDR;
        end
      end
      OUT: begin
        if (i_cmd_ready) begin
          state_d = HDR;
        end
      end
      default: state_d = HDR;
    endcase
  end

  // Outputs decoded from the current state: FIFO pop strobe and busy flag.
  always_comb begin
    pop       = (state_q != OUT) && !i_fifo_empty && i_resetn;
    o_fifo_rd = pop;
    o_busy    = (state_q != HDR);
  end

  // Packet fields, word counter, sticky error and registered valid.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      o_cmd_valid   <= 1'b0;
      o_cmd_op      <= '0;
      o_cmd_len     <= '0;
      o_cmd_payload <= '0;
      o_err         <= 1'b0;
      cnt_q         <= '0;
    end else begin
      o_cmd_valid <= (state_d == OUT);
      if (pop) begin
        case (state_q)
          HDR: begin
            o_cmd_payload <= '0;
            if (hdr_len > MAXW_L) begin
              // Oversized command: keep the previous op/len, count the junk down.
              o_err <= 1'b1;
              cnt_q <= hdr_len;
            end else begin
              o_cmd_op  <= i_fifo_data[DW-1 -: 8];
              o_cmd_len <= hdr_len;
              cnt_q     <= '0;
            end
          end
          PAY: begin
            for (int unsigned k = 0; k < MAXW; k++) begin
              if (k == 32'(cnt_q)) begin
                o_cmd_payload[k*DW +: DW] <= i_fifo_data;
              end
            end
            cnt_q <= cnt_q + 4'd1;
          end
          DRAIN: begin
            cnt_q <= cnt_q - 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_word_parser.sv
// tb_cmd_word_parser: FIFO emulation with random gaps and random downstream
// backpressure, checked against a stream-level command parser model.
module tb_cmd_word_parser;

  localparam int DW   = 32;
  localparam int MAXW = 4;
  localparam int PW   = DW * MAXW;

  typedef logic [DW-1:0] word_t;
  typedef word_t word_q_t[$];
  typedef struct {
    logic [7:0]    op;
    logic [3:0]    len;
    logic [PW-1:0] pay;
  } pkt_t;

  logic          clk = 1'b0;
  logic          i_resetn = 1'b0;
  logic          i_fifo_empty = 1'b1;
  logic [DW-1:0] i_fifo_data = '0;
  logic          o_fifo_rd;
  logic          o_cmd_valid;
  logic          i_cmd_ready = 1'b0;
  logic [7:0]    o_cmd_op;
  logic [3:0]    o_cmd_len;
  logic [PW-1:0] o_cmd_payload;
  logic          o_err;
  logic          o_busy;

  cmd_word_parser #(.DW(DW), .MAXW(MAXW)) dut (
    .i_clk         (clk),
    .i_resetn      (i_resetn),
    .i_fifo_empty  (i_fifo_empty),
    .i_fifo_data   (i_fifo_data),
    .o_fifo_rd     (o_fifo_rd),
    .o_cmd_valid   (o_cmd_valid),
    .i_cmd_ready   (i_cmd_ready),
    .o_cmd_op      (o_cmd_op),
    .o_cmd_len     (o_cmd_len),
    .o_cmd_payload (o_cmd_payload),
    .o_err         (o_err),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  int      nvec = 0;
  int      nerr = 0;
  word_t   fq[$];     // words sitting in the emulated FIFO
  logic    fbad[$];   // per FIFO word: is it an oversized header
  pkt_t    expq[$];   // packets the stream must produce, in order
  logic    err_exp = 1'b0;
  logic    prev_hs = 1'b0;
  int      gap_pct = 0;
  int      rdy_pct = 100;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Parse a word stream by the command rules and queue it for the FIFO.
  task automatic model_append(input word_q_t ws);
    int   i;
    int   l;
    pkt_t p;
    i = 0;
    while (i < ws.size()) begin
      l = int'(ws[i][3:0]);
      fq.push_back(ws[i]);
      fbad.push_back(l > MAXW);
      p.op  = ws[i][DW-1 -: 8];
      p.len = ws[i][3:0];
      p.pay = '0;
      i++;
      for (int j = 0; j < l && i < ws.size(); j++) begin
        fq.push_back(ws[i]);
        fbad.push_back(1'b0);
        if (l <= MAXW) p.pay[j*DW +: DW] = ws[i];
        i++;
      end
      if (l <= MAXW) expq.push_back(p);
    end
  endtask

  task automatic set_inputs();
    i_fifo_empty = (fq.size() == 0) || ($urandom_range(99) < gap_pct);
    i_fifo_data  = (fq.size() != 0) ? fq[0] : word_t'($urandom);
    i_cmd_ready  = ($urandom_range(99) < rdy_pct);
  endtask

  // One clock: check outputs at the negedge, apply FIFO/handshake effects at the posedge.
  task automatic step();
    logic    rd;
    logic    emp;
    logic    hs;
    word_q_t tmp;
    @(negedge clk);
    emp = i_fifo_empty;
    rd  = o_fifo_rd;
    chk("rd_when_empty", rd & emp, 0);
    if (!i_resetn) chk("rd_in_reset", rd, 0);
    if (o_cmd_valid) begin
      chk("rd_in_out", rd, 0);
      chk("busy_in_out", o_busy, 1);
      if (expq.size() == 0) begin
        chk("spurious_valid", o_cmd_valid, 0);
      end else begin
        chk("op", o_cmd_op, expq[0].op);
        chk("len", o_cmd_len, expq[0].len);
        chk("payload", o_cmd_payload, expq[0].pay);
      end
    end
    if (prev_hs) chk("valid_after_accept", o_cmd_valid, 0);
    chk("err", o_err, err_exp);
    hs = o_cmd_valid & i_cmd_ready;
    @(posedge clk);
    if (!i_resetn) begin
      tmp = fq;
      fq.delete();
      fbad.delete();
      expq.delete();
      err_exp = 1'b0;
      model_append(tmp);
      prev_hs = 1'b0;
    end else begin
      if (rd && !emp && fq.size() != 0) begin
        void'(fq.pop_front());
        if (fbad.pop_front()) err_exp = 1'b1;
      end
      if (hs && expq.size() != 0) void'(expq.pop_front());
      prev_hs = hs;
    end
    #1;
    set_inputs();
  endtask

  task automatic run_stream(input int gp, input int rp, input int budget);
    gap_pct = gp;
    rdy_pct = rp;
    set_inputs();
    for (int c = 0; c < budget; c++) begin
      if (fq.size() == 0 && expq.size() == 0 && !o_cmd_valid && !o_busy) break;
      step();
    end
    chk("pending_at_end", 32'(fq.size() + expq.size()), 0);
    chk("idle_busy", o_busy, 0);
  endtask

  word_q_t ws;
  int      l;

  initial begin
    i_resetn = 1'b0;
    set_inputs();
    step();
    step();
    i_resetn = 1'b1;
    chk("rst_valid", o_cmd_valid, 0);
    chk("rst_op", o_cmd_op, 0);
    chk("rst_len", o_cmd_len, 0);
    chk("rst_payload", o_cmd_payload, 0);
    chk("rst_err", o_err, 0);
    chk("rst_busy", o_busy, 0);

    // Zero-length command.
    ws = '{32'h1100_0000};
    model_append(ws);
    run_stream(0, 100, 50);

    // Two payload words, back to back.
    ws = '{32'h2200_0002, 32'hAAAA_AAAA, 32'hBBBB_BBBB};
    model_append(ws);
    run_stream(0, 100, 50);

    // Backpressure with the next header already waiting.
    ws = '{32'h2200_0002, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'h2300_0000};
    model_append(ws);
    run_stream(0, 20, 200);

    // Empty gaps between payload words.
    ws = '{32'h3300_0003, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
    model_append(ws);
    run_stream(70, 100, 200);

    // Oversized header drained, then a valid command; error stays set.
    ws = '{32'h4400_0006, 32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002,
           32'hDEAD_0003, 32'hDEAD_0004, 32'hDEAD_0005,
           32'h5500_0001, 32'h1234_5678};
    model_append(ws);
    run_stream(0, 100, 100);
    chk("err_sticky", o_err, 1);

    // Reset in the middle of a command; the next word becomes a header.
    ws = '{32'h6600_0003, 32'hDEAD_0001, 32'h7700_0001, 32'h0BAD_F00D};
    model_append(ws);
    gap_pct = 0;
    rdy_pct = 100;
    set_inputs();
    step();
    step();
    chk("busy_mid_cmd", o_busy, 1);
    i_resetn = 1'b0;
    step();
    i_resetn = 1'b1;
    chk("midrst_valid", o_cmd_valid, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_err", o_err, 0);
    run_stream(0, 100, 100);

    // Random command streams with random gaps and backpressure.
    for (int s = 0; s < 12; s++) begin
      ws.delete();
      for (int c = 0; c < 6; c++) begin
        if ($urandom_range(9) < 8) l = $urandom_range(MAXW, 0);
        else l = $urandom_range(15, MAXW + 1);
        ws.push_back({8'($urandom), 20'($urandom), 4'(l)});
        for (int j = 0; j < l; j++) ws.push_back(word_t'($urandom));
      end
      model_append(ws);
      run_stream($urandom_range(60), $urandom_range(100, 20), 3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
